// File: rtl/safe_irq_bridge.sv
// ---------------------------------------------------------------------------
// safe_irq_bridge
//
// Per-hart interrupt bridge between the safety-mode FSM and the cores.
// Level sync/halt requests from the FSM are edge-detected and turned into
// latched core interrupt lines.  Each line is held until the core reports an
// acknowledge carrying the matching interrupt ID.  A level acknowledge per
// hart goes back to the FSM.  Harts that leave a sync interrupt pending for
// too long are flagged in a sticky error bit.
//
// Ports:
//   clk_i              clock, all logic on the rising edge
//   rst_i              synchronous active-high reset
//   sync_req_i         [NHARTS]    sync request per hart (level)
//   halt_req_i         [NHARTS]    halt request per hart (level)
//   core_irq_ack_i     [NHARTS]    core interrupt-ack strobe, one cycle per ack
//   core_irq_ack_id_i  [NHARTS*5]  acknowledged ID, hart i at [5i+4:5i]
//   err_clr_i          [NHARTS]    clears err_o[i]
//   irq_sync_o         [NHARTS]    sync interrupt line to core i
//   irq_halt_o         [NHARTS]    halt interrupt line to core i
//   hart_intc_ack_o    [NHARTS]    level acknowledge back to the FSM
//   err_o              [NHARTS]    sticky sync-timeout flag
// ---------------------------------------------------------------------------
module safe_irq_bridge #(
    parameter int unsigned NHARTS         = 3,
    parameter logic [4:0]  SYNC_IRQ_ID    = 5'd31,
    parameter logic [4:0]  HALT_IRQ_ID    = 5'd30,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NHARTS-1:0]     sync_req_i,
    input  logic [NHARTS-1:0]     halt_req_i,
    input  logic [NHARTS-1:0]     core_irq_ack_i,
    input  logic [NHARTS*5-1:0]   core_irq_ack_id_i,
    input  logic [NHARTS-1:0]     err_clr_i,
    output logic [NHARTS-1:0]     irq_sync_o,
    output logic [NHARTS-1:0]     irq_halt_o,
    output logic [NHARTS-1:0]     hart_intc_ack_o,
    output logic [NHARTS-1:0]     err_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_ACKED,
        S_ERR
    } sync_state_t;

    sync_state_t       state      [NHARTS];
    sync_state_t       state_next [NHARTS];
    logic [CW-1:0]     cnt        [NHARTS];
    logic [CW-1:0]     cnt_next   [NHARTS];

    logic [NHARTS-1:0] sync_q;
    logic [NHARTS-1:0] halt_q;
    logic [NHARTS-1:0] sync_rise;
    logic [NHARTS-1:0] halt_rise;
    logic [NHARTS-1:0] sync_ack;
    logic [NHARTS-1:0] halt_ack;
    logic [NHARTS-1:0] pend;
    logic [NHARTS-1:0] pend_next;
    logic [NHARTS-1:0] err;
    logic [NHARTS-1:0] err_next;
    logic [NHARTS-1:0] err_set;
    logic [NHARTS-1:0] irq_sync;
    logic [NHARTS-1:0] hart_ack;

    // Edge detection and ack qualification.  An ack whose ID matches
    // neither channel is dropped here.
    always_comb begin
        sync_rise = sync_req_i & ~sync_q;
        halt_rise = halt_req_i & ~halt_q;
        sync_ack  = '0;
        halt_ack  = '0;
        for (int unsigned i = 0; i < NHARTS; i++) begin
            sync_ack[i] = core_irq_ack_i[i] && (core_irq_ack_id_i[5*i +: 5] == SYNC_IRQ_ID);
            halt_ack[i] = core_irq_ack_i[i] && (core_irq_ack_id_i[5*i +: 5] == HALT_IRQ_ID);
        end
    end

    // Sync channel: next state, counter and Moore outputs.
    always_comb begin
        err_set  = '0;
        irq_sync = '0;
        hart_ack = '0;
        for (int unsigned i = 0; i < NHARTS; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            case (state[i])
                S_IDLE: begin
                    if (sync_rise[i]) begin
                        state_next[i] = S_PEND;
                        cnt_next[i]   = '0;
                    end
                end
                S_PEND: begin
                    irq_sync[i] = 1'b1;
                    // The ack is checked first so an ack on the final
                    // timeout cycle still completes the handshake.
                    if (sync_ack[i]) begin
                        state_next[i] = S_ACKED;
                    end else if (cnt[i] == CNT_MAX) begin
                        state_next[i] = S_ERR;
                        err_set[i]    = 1'b1;
                    end else begin
                        cnt_next[i] = cnt[i] + CW'(1);
                    end
                end
                S_ACKED: begin
                    // Held while the request is held so every hart's ack
                    // overlaps for the FSM's AND condition.
                    hart_ack[i] = 1'b1;
                    if (!sync_req_i[i]) begin
                        state_next[i] = S_IDLE;
                    end
                end
                S_ERR: begin
                    if (!sync_req_i[i]) begin
                        state_next[i] = S_IDLE;
                    end
                end
                default: begin
                    state_next[i] = S_IDLE;
                end
            endcase
        end
    end

    // Halt pend bit and sticky error: set wins over clear in both.
    always_comb begin
        pend_next = halt_rise | (pend & ~halt_ack);
        err_next  = err_set | (err & ~err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            halt_q <= '0;
            pend   <= '0;
            err    <= '0;
            for (int unsigned i = 0; i < NHARTS; i++) begin
                state[i] <= S_IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            sync_q <= sync_req_i;
            halt_q <= halt_req_i;
            pend   <= pend_next;
            err    <= err_next;
            for (int unsigned i = 0; i < NHARTS; i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
        end
    end

    assign irq_sync_o      = irq_sync;
    assign irq_halt_o      = pend;
    assign hart_intc_ack_o = hart_ack;
    assign err_o           = err;

endmodule
